// File: rtl/ap_r_seq_ctrl.sv
// Result-array sequencer for the associative processor.
// One job per start: row-write DATA_DEPTH words from the input stream, step the
// compare/write schedule over every bit column, then read every row back out.
// All array-facing outputs are registered and line up with the FSM state they
// belong to, so the array sees each phase in the same cycle the FSM is in it.
module ap_r_seq_ctrl #(
    parameter int         DATA_WIDTH     = 4,
    parameter int         DATA_DEPTH     = 4,
    parameter int         ADDR_WIDTH_CAM = 8,
    parameter int         NUM_PASS       = 3,
    parameter logic [2:0] RowxRow        = 3'd1,
    parameter logic [2:0] MODE_IDLE      = 3'd0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      abs_en,
    output logic                      busy,
    output logic                      done,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_WIDTH-1:0]     in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_WIDTH-1:0]     out_data,
    input  logic [DATA_WIDTH-1:0]     q_out_row,
    output logic [2:0]                input_mode,
    output logic [ADDR_WIDTH_CAM-1:0] addr_input_Row,
    output logic [ADDR_WIDTH_CAM-1:0] addr_output_Row,
    output logic [DATA_WIDTH-1:0]     Ip_row,
    output logic                      rstIn,
    output logic [2:0]                Pass,
    output logic [DATA_WIDTH-1:0]     Mask,
    output logic                      ABS_opt
);

    // One extra bit so the row counter can reach DATA_DEPTH, which marks the
    // cycle in LOAD where the last write is on the array bus.
    localparam int CW = ADDR_WIDTH_CAM + 1;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] LOAD    = 3'd1;
    localparam logic [2:0] CMP     = 3'd2;
    localparam logic [2:0] WR      = 3'd3;
    localparam logic [2:0] RD_ADDR = 3'd4;
    localparam logic [2:0] RD_WAIT = 3'd5;
    localparam logic [2:0] RD_OUT  = 3'd6;
    localparam logic [2:0] DONE    = 3'd7;

    logic [2:0]                state_q, state_d;
    logic [CW-1:0]             row_q, row_d;
    logic [ADDR_WIDTH_CAM-1:0] col_q, col_d;
    logic [2:0]                pass_q, pass_d;
    logic                      wait_q, wait_d;

    logic                      accept;
    logic                      last_row_loaded;
    logic                      last_row_read;
    logic                      last_pass;
    logic                      last_col;

    logic                      busy_d;
    logic                      done_d;
    logic                      out_valid_d;
    logic [DATA_WIDTH-1:0]     out_data_d;
    logic [2:0]                input_mode_d;
    logic [ADDR_WIDTH_CAM-1:0] addr_input_row_d;
    logic [ADDR_WIDTH_CAM-1:0] addr_output_row_d;
    logic [DATA_WIDTH-1:0]     ip_row_d;
    logic                      rstin_d;
    logic [2:0]                pass_out_d;
    logic [DATA_WIDTH-1:0]     mask_d;
    logic                      abs_opt_d;

    // Load handshake and end-of-phase conditions.
    assign in_ready        = (state_q == LOAD) && (row_q < CW'(DATA_DEPTH));
    assign accept          = in_valid && in_ready;
    assign last_row_loaded = (row_q == CW'(DATA_DEPTH));
    assign last_row_read   = (row_q == CW'(DATA_DEPTH - 1));
    assign last_pass       = (pass_q == 3'(NUM_PASS));
    assign last_col        = (col_q == ADDR_WIDTH_CAM'(DATA_WIDTH - 1));

    // Next-state and counter logic for the three job phases.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        pass_d  = pass_q;
        wait_d  = wait_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    row_d   = '0;
                end
            end
            LOAD: begin
                if (accept) begin
                    row_d = row_q + CW'(1);
                end else if (last_row_loaded) begin
                    // Final row write is on the bus this cycle; compute next.
                    state_d = CMP;
                    col_d   = '0;
                    pass_d  = 3'd1;
                end
            end
            CMP: begin
                state_d = WR;
            end
            WR: begin
                state_d = CMP;
                if (last_pass) begin
                    pass_d = 3'd1;
                    if (last_col) begin
                        state_d = RD_ADDR;
                        row_d   = '0;
                    end else begin
                        col_d = col_q + ADDR_WIDTH_CAM'(1);
                    end
                end else begin
                    pass_d = pass_q + 3'd1;
                end
            end
            RD_ADDR: begin
                state_d = RD_WAIT;
                wait_d  = 1'b0;
            end
            RD_WAIT: begin
                // Two wait cycles cover the array's registered enable and data.
                if (wait_q) begin
                    state_d = RD_OUT;
                end else begin
                    wait_d = 1'b1;
                end
            end
            RD_OUT: begin
                if (out_ready) begin
                    if (last_row_read) begin
                        state_d = DONE;
                    end else begin
                        state_d = RD_ADDR;
                        row_d   = row_q + CW'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Registered outputs are derived from the next state so they are valid
    // in the same cycle as the state they describe.
    always_comb begin
        busy_d       = (state_d != IDLE);
        done_d       = (state_d == DONE);
        out_valid_d  = (state_d == RD_OUT);
        out_data_d   = out_data;
        if ((state_q == RD_WAIT) && wait_q) begin
            out_data_d = q_out_row;
        end

        input_mode_d = MODE_IDLE;
        if ((state_d == LOAD) || (state_d == RD_ADDR) || (state_d == RD_WAIT) ||
            (state_d == RD_OUT)) begin
            input_mode_d = RowxRow;
        end

        // A row write lasts exactly one cycle after each accepted beat.
        rstin_d          = ~accept;
        addr_input_row_d = addr_input_Row;
        ip_row_d         = Ip_row;
        if (accept) begin
            addr_input_row_d = row_q[ADDR_WIDTH_CAM-1:0];
            ip_row_d         = in_data;
        end

        addr_output_row_d = addr_output_Row;
        if (state_d == RD_ADDR) begin
            addr_output_row_d = row_d[ADDR_WIDTH_CAM-1:0];
        end

        pass_out_d = 3'd0;
        if ((state_d == CMP) || (state_d == WR)) begin
            pass_out_d = pass_d;
        end

        mask_d = '0;
        if (state_d == WR) begin
            mask_d = DATA_WIDTH'(1) << col_d;
        end

        abs_opt_d = ABS_opt;
        if ((state_q == IDLE) && start) begin
            abs_opt_d = abs_en;
        end
    end

    // FSM state and job counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            pass_q  <= 3'd0;
            wait_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            pass_q  <= pass_d;
            wait_q  <= wait_d;
        end
    end

    // Job status and output stream registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            busy      <= busy_d;
            done      <= done_d;
            out_valid <= out_valid_d;
            out_data  <= out_data_d;
        end
    end

    // Array control registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            input_mode      <= MODE_IDLE;
            addr_input_Row  <= '0;
            addr_output_Row <= '0;
            Ip_row          <= '0;
            rstIn           <= 1'b1;
            Pass            <= 3'd0;
            Mask            <= '0;
            ABS_opt         <= 1'b0;
        end else begin
            input_mode      <= input_mode_d;
            addr_input_Row  <= addr_input_row_d;
            addr_output_Row <= addr_output_row_d;
            Ip_row          <= ip_row_d;
            rstIn           <= rstin_d;
            Pass            <= pass_out_d;
            Mask            <= mask_d;
            ABS_opt         <= abs_opt_d;
        end
    end

endmodule

// File: tb/tb_ap_r_seq_ctrl.sv
// Directed bench for ap_r_seq_ctrl: table of jobs plus a mid-job reset sequence.
module tb_ap_r_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       abs_en = 1'b0;
    logic       busy, done;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_data = 4'h0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [3:0] out_data;
    logic [3:0] q_out_row = 4'h0;
    logic [2:0] input_mode;
    logic [7:0] addr_input_Row, addr_output_Row;
    logic [3:0] Ip_row;
    logic       rstIn;
    logic [2:0] Pass;
    logic [3:0] Mask;
    logic       ABS_opt;

    ap_r_seq_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .abs_en(abs_en), .busy(busy), .done(done),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .q_out_row(q_out_row), .input_mode(input_mode), .addr_input_Row(addr_input_Row),
        .addr_output_Row(addr_output_Row), .Ip_row(Ip_row), .rstIn(rstIn), .Pass(Pass),
        .Mask(Mask), .ABS_opt(ABS_opt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        abs_en;
        logic [15:0] ld;
        logic [15:0] rd;
        int          in_stall_beat;
        int          in_stall_n;
        int          out_stall_beat;
        int          out_stall_n;
        bit          busy_starts;
    } vec_t;

    vec_t vecs [3];
    int   nvec = 0;
    int   nerr = 0;

    // Array read model: registered address, then registered data.
    logic [3:0] rd_mem [4];
    logic [7:0] rd_a1 = 8'h0;
    always @(posedge clk) begin
        rd_a1     <= addr_output_Row;
        q_out_row <= rd_mem[rd_a1[1:0]];
    end

    // Observation of array and stream activity, sampled on the falling edge.
    logic        mon_clr = 1'b0;
    int          cyc = 0;
    logic [14:0] wr_log [8];
    int          wr_cnt = 0;
    logic [10:0] cp_log [32];
    int          cp_cnt = 0, cp_first = 0, cp_last = 0;
    logic [3:0]  bt_log [8];
    int          bt_cnt = 0;
    int          done_cnt = 0, lat_err = 0, stall_wr_err = 0, stab_err = 0, stall_cyc = 0;
    int          addr_cyc = 0;
    logic [7:0]  prev_addr = 8'h0;
    logic [2:0]  prev_pass = 3'd0;
    logic        prev_valid = 1'b0;
    logic [3:0]  prev_data = 4'h0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (mon_clr) begin
            wr_cnt <= 0; cp_cnt <= 0; bt_cnt <= 0; done_cnt <= 0; lat_err <= 0;
            stall_wr_err <= 0; stab_err <= 0; stall_cyc <= 0;
        end else begin
            if (!rstIn) begin
                if (wr_cnt < 8) wr_log[wr_cnt] <= {input_mode, addr_input_Row, Ip_row};
                wr_cnt <= wr_cnt + 1;
            end
            if (Pass != 3'd0) begin
                if (cp_cnt < 32) cp_log[cp_cnt] <= {Pass, Mask, input_mode, ABS_opt};
                if (cp_cnt == 0) cp_first <= cyc;
                cp_last <= cyc;
                cp_cnt  <= cp_cnt + 1;
            end
            if (out_valid && !prev_valid && (cyc - addr_cyc < 3)) lat_err <= lat_err + 1;
            if (out_valid && (!rstIn || Mask != 4'h0)) stall_wr_err <= stall_wr_err + 1;
            if (out_valid && !out_ready) begin
                stall_cyc <= stall_cyc + 1;
                if (prev_valid && prev_data != out_data) stab_err <= stab_err + 1;
            end
            if (out_valid && out_ready) begin
                if (bt_cnt < 8) bt_log[bt_cnt] <= out_data;
                bt_cnt <= bt_cnt + 1;
            end
            if (done) done_cnt <= done_cnt + 1;
        end
        if ((addr_output_Row != prev_addr) || (Pass == 3'd0 && prev_pass != 3'd0)) addr_cyc <= cyc;
        prev_addr  <= addr_output_Row;
        prev_pass  <= Pass;
        prev_valid <= out_valid;
        prev_data  <= out_data;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_rst_vals(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_out_data"}, 32'(out_data), 32'd0);
        chk({tag, "_mode"}, 32'(input_mode), 32'd0);
        chk({tag, "_addr_in"}, 32'(addr_input_Row), 32'd0);
        chk({tag, "_addr_out"}, 32'(addr_output_Row), 32'd0);
        chk({tag, "_ip_row"}, 32'(Ip_row), 32'd0);
        chk({tag, "_rstIn"}, 32'(rstIn), 32'd1);
        chk({tag, "_pass"}, 32'(Pass), 32'd0);
        chk({tag, "_mask"}, 32'(Mask), 32'd0);
        chk({tag, "_abs"}, 32'(ABS_opt), 32'd0);
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1;
        step();
        mon_clr = 1'b0;
    endtask

    // Start a job and push its four load words, honouring the vector's stalls.
    task automatic start_and_load(input vec_t v);
        for (int i = 0; i < 4; i++) rd_mem[i] = v.rd[4*i +: 4];
        start  = 1'b1;
        abs_en = v.abs_en;
        step();
        start  = 1'b0;
        abs_en = ~v.abs_en;
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("in_ready_in_load", 32'(in_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            int g;
            if (i == v.in_stall_beat) begin
                in_valid = 1'b0;
                repeat (v.in_stall_n) step();
            end
            in_valid = 1'b1;
            in_data  = v.ld[4*i +: 4];
            if (v.busy_starts && i == 1) start = 1'b1;
            g = 0;
            while (!in_ready && g < 50) begin
                step();
                g++;
            end
            if (g == 50) chk("in_ready_timeout", 32'd0, 32'd1);
            step();
            start = 1'b0;
        end
        in_valid = 1'b0;
        chk("in_ready_low_after_last", 32'(in_ready), 32'd0);
    endtask

    task automatic run_job(input int idx);
        vec_t v;
        int   hold;
        bit   got_done;
        v = vecs[idx];
        clear_mon();
        start_and_load(v);
        out_ready = 1'b1;
        hold      = 0;
        got_done  = 1'b0;
        for (int c = 0; c < 600 && !got_done; c++) begin
            step();
            if (done) begin
                got_done = 1'b1;
            end else if (out_valid && bt_cnt == v.out_stall_beat && hold < v.out_stall_n) begin
                out_ready = 1'b0;
                hold++;
                start = (v.busy_starts && hold == 3);
            end else begin
                out_ready = 1'b1;
                start     = 1'b0;
            end
        end
        start     = 1'b0;
        out_ready = 1'b1;
        chk("done_reached", 32'(got_done), 32'd1);
        chk("busy_at_done", 32'(busy), 32'd1);
        step();
        chk("busy_after_done", 32'(busy), 32'd0);
        chk("done_one_cycle", 32'(done), 32'd0);
        repeat (3) step();
        chk("stays_idle", 32'(busy), 32'd0);
        chk("done_count", 32'(done_cnt), 32'd1);

        chk("write_count", 32'(wr_cnt), 32'd4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("write%0d", i), 32'(wr_log[i]), 32'({3'd1, 8'(i), v.ld[4*i +: 4]}));

        chk("compute_cycles", 32'(cp_cnt), 32'd24);
        chk("compute_span", 32'(cp_last - cp_first + 1), 32'd24);
        for (int k = 0; k < 24; k++) begin
            int         col;
            logic [2:0] p;
            logic [3:0] m;
            col = k / 6;
            p   = 3'((k % 6) / 2 + 1);
            m   = (k % 2 == 1) ? 4'(1 << col) : 4'h0;
            chk($sformatf("compute%0d", k), 32'(cp_log[k]), 32'({p, m, 3'd0, v.abs_en}));
        end

        chk("beat_count", 32'(bt_cnt), 32'd4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("beat%0d", i), 32'(bt_log[i]), 32'(v.rd[4*i +: 4]));
        chk("read_latency", 32'(lat_err), 32'd0);
        chk("no_write_in_readout", 32'(stall_wr_err), 32'd0);
        chk("out_data_stable", 32'(stab_err), 32'd0);
        chk("out_stall_cycles", 32'(stall_cyc), 32'(v.out_stall_n < 0 ? 0 : v.out_stall_n));
    endtask

    initial begin
        vecs[0] = '{abs_en: 1'b1, ld: 16'hFA53, rd: 16'h9999, in_stall_beat: -1, in_stall_n: 0,
                    out_stall_beat: -1, out_stall_n: -1, busy_starts: 1'b0};
        vecs[1] = '{abs_en: 1'b0, ld: 16'h8421, rd: 16'hE36C, in_stall_beat: 2, in_stall_n: 5,
                    out_stall_beat: 1, out_stall_n: 10, busy_starts: 1'b1};
        vecs[2] = '{abs_en: 1'b1, ld: 16'h970F, rd: 16'h4321, in_stall_beat: 0, in_stall_n: 3,
                    out_stall_beat: 3, out_stall_n: 2, busy_starts: 1'b0};
        for (int i = 0; i < 4; i++) rd_mem[i] = 4'h0;

        #12;
        chk_rst_vals("reset");
        step();
        rst = 1'b1;
        step();
        chk_rst_vals("idle");

        for (int j = 0; j < 3; j++) run_job(j);

        // Abort in the compute phase at column 2, pass 2.
        begin
            int g;
            clear_mon();
            start_and_load(vecs[1]);
            g = 0;
            while (!(Pass == 3'd2 && Mask == 4'h4) && g < 100) begin
                step();
                g++;
            end
            chk("reached_col2_pass2", 32'(g < 100), 32'd1);
            #2 rst = 1'b0;
            #1;
            chk_rst_vals("abort");
            step();
            step();
            rst = 1'b1;
            repeat (5) step();
            chk("abort_no_done", 32'(done_cnt), 32'd0);
            chk("abort_idle", 32'(busy), 32'd0);
        end

        run_job(0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/ap_r_seq_ctrl.md
Name: ap_r_seq_ctrl

Overview:
- Sequencer for the associative processor's result-register array (row/column-addressable CAM cell array with Pass/Mask/tag-driven write-back).
- Runs one job per `start`, in three phases:
  - loads DATA_DEPTH words through a valid/ready input stream using row-write mode;
  - steps the multi-pass compare/write schedule across every bit column;
  - streams all rows back out through a valid/ready output stream.
- Sits between the AP top-level controller and the result-array instance, and is the array's only driver.

Parameters:
- DATA_WIDTH, 4, word width (array columns).
- DATA_DEPTH, 4, number of words (array rows).
- ADDR_WIDTH_CAM, 8, row/column address width.
- NUM_PASS, 3, passes per bit column (1..7).
- RowxRow, 3'd1, array row-access mode code.
- MODE_IDLE, 3'd0, array mode code during compute and idle (tag write-back only).

Ports:
- clk, input, 1: clock, rising edge.
- rst, input, 1: reset, asynchronous, active-low.
- start, input, 1: begin a job; sampled in IDLE only.
- abs_en, input, 1: captured at start, drives ABS_opt for the whole job.
- busy, output, 1: high from the cycle after start is accepted until done.
- done, output, 1: one-cycle pulse after the last output beat.
- in_valid, input, 1: load beat valid.
- in_ready, output, 1: high only in LOAD.
- in_data, input, DATA_WIDTH: load word.
- out_valid, output, 1: output beat valid.
- out_ready, input, 1: consumer accept.
- out_data, output, DATA_WIDTH: output word, registered.
- q_out_row, input, DATA_WIDTH: row read data from the array.
- input_mode, output, 3: array mode select.
- addr_input_Row, output, ADDR_WIDTH_CAM: array write row.
- addr_output_Row, output, ADDR_WIDTH_CAM: array read row.
- Ip_row, output, DATA_WIDTH: array write data.
- rstIn, output, 1: array write inhibit. Low means the row write is enabled.
- Pass, output, 3: current pass number. 0 means none.
- Mask, output, DATA_WIDTH: one-hot column write mask.
- ABS_opt, output, 1: absolute-value option to the array.

Behaviour:
- Reset values (asynchronous, rst low):
  - state = IDLE; all counters 0.
  - busy, done, in_ready, out_valid = 0; out_data = 0.
  - input_mode = MODE_IDLE; addresses = 0; Ip_row = 0; rstIn = 1; Pass = 0; Mask = 0; ABS_opt = 0.
- Reset mid-job aborts the job immediately. Nothing is retained, and no done pulse is produced.
- All array-facing outputs are registered.
- States: IDLE, LOAD, CMP, WR, RD_ADDR, RD_WAIT, RD_OUT, DONE.
- IDLE:
  - start=1 → LOAD; row counter = 0; abs_en latched into ABS_opt.
  - start while busy is ignored.
- LOAD:
  - input_mode = RowxRow; in_ready = 1.
  - On an in_valid & in_ready cycle, the next cycle drives rstIn = 0, addr_input_Row = row, Ip_row = in_data for exactly one cycle; row increments.
  - Otherwise rstIn = 1.
  - After the beat for row DATA_DEPTH-1 is accepted: in_ready drops the same cycle, the final write is issued, then → CMP with col = 0, pass = 1.
- CMP:
  - input_mode = MODE_IDLE; Pass = pass; Mask = 0. The external CAM resolves tags during this cycle.
  - Lasts 1 cycle, then → WR.
- WR:
  - Pass = pass; Mask = 1 << col; 1 cycle.
  - Then pass increments. When pass == NUM_PASS: pass = 1, col increments.
  - When col == DATA_WIDTH-1 and pass == NUM_PASS → RD_ADDR with row = 0.
- Compute phase length: exactly 2·DATA_WIDTH·NUM_PASS cycles.
- Pass and Mask return to 0 on leaving WR for the last time.
- RD_ADDR:
  - input_mode = RowxRow; rstIn = 1; addr_output_Row = row; 1 cycle → RD_WAIT.
- RD_WAIT:
  - 2 cycles. This matches the array's registered enable plus registered data, i.e. 2-cycle read latency.
  - On the last wait cycle, capture q_out_row into out_data → RD_OUT.
- RD_OUT:
  - out_valid = 1; out_data is held stable until out_ready.
  - On handshake: out_valid drops. If row == DATA_DEPTH-1 → DONE; else row increments → RD_ADDR.
- DONE: done = 1 for 1 cycle; busy = 0 from the next cycle → IDLE.
- Backpressure: in_valid low stalls LOAD indefinitely. out_ready low stalls RD_OUT indefinitely. The array receives no writes while stalled (rstIn = 1, Mask = 0).
- Address width: row and col counters are zero-extended to ADDR_WIDTH_CAM. DATA_DEPTH and DATA_WIDTH must each be ≤ 2^ADDR_WIDTH_CAM.

Test Plan:
- Reset, then start, then 4 beats 0x3, 0x5, 0xA, 0xF with in_valid held → rstIn low on exactly 4 cycles; addr_input_Row 0, 1, 2, 3 with matching Ip_row; in_ready low after the 4th beat.
- Compute schedule (W=4, P=3) → exactly 24 cycles. Mask sequence is 0 / 0x1 alternating for passes 1, 2, 3, then 0 / 0x2, and so on up to 0x8. Pass cycles 1, 2, 3 per column; ABS_opt equals the latched abs_en throughout.
- Readback with an array model returning row value 0x9 for each row → 4 output beats of 0x9. Each beat appears ≥3 cycles after its addr_output_Row change. done pulses once; busy falls the next cycle.
- Backpressure: hold out_ready = 0 for 10 cycles on beat 2 → out_valid and out_data stable, no array writes, beat delivered when out_ready = 1. Stall in_valid for 5 cycles mid-LOAD → no spurious write.
- Assert rst during the compute phase at col=2, pass=2 → every output is at its reset value asynchronously; a subsequent start runs a full, correct job.
- Start pulsed while busy, in the LOAD and RD_OUT states → ignored; the job completes normally with one done pulse.
